ball_physics: RTL and testbench

Parametrised ball-motion and rendering engine that succeeds the single-ball game logic in the VGA game pipeline. It reads button inputs once per frame and updates a signed velocity with saturation, periodic friction and wall bounce. It renders a filled circle through a 2-stage pixel pipeline. It sits between the VGA timing generator (h_coord/v_coord) and the RGB output mux.

---
 rtl/ball_physics.sv | 179 +++++++++++++++++
 tb/tb_ball_physics.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_physics.sv
// Ball motion and rendering engine: per-frame velocity/position update with
// saturation, friction and wall bounce, plus a 2-stage filled-circle renderer.
module ball_physics #(
    parameter int          H_ACTIVE         = 800,
    parameter int          V_ACTIVE         = 600,
    parameter int          RADIUS           = 10,
    parameter int          VMAX             = 15,
    parameter int          SPEED_W          = 6,
    parameter int          FRAMES_PER_DECEL = 5,
    parameter int          START_X          = 400,
    parameter int          START_Y          = 300,
    parameter logic [11:0] COLOR            = 12'hFFF
) (
    input  logic                      pixel_clk,
    input  logic                      rst_n,
    input  logic                      button_u,
    input  logic                      button_d,
    input  logic                      button_l,
    input  logic                      button_r,
    input  logic                      button_c,
    input  logic [9:0]                h_coord,
    input  logic [9:0]                v_coord,
    output logic [3:0]                red,
    output logic [3:0]                green,
    output logic [3:0]                blue,
    output logic [9:0]                ball_x,
    output logic [9:0]                ball_y,
    output logic signed [SPEED_W-1:0] speed_x,
    output logic signed [SPEED_W-1:0] speed_y,
    output logic                      moving,
    output logic                      bounce
);

    // state  | meaning
    // IDLE   | both speeds are zero
    // MOVING | at least one speed is nonzero
    typedef enum logic {IDLE, MOVING} state_t;

    localparam int FC_W = (FRAMES_PER_DECEL > 1) ? $clog2(FRAMES_PER_DECEL) : 1;
    localparam int AXIS_W = 1 + 10 + SPEED_W;
    localparam logic [FC_W-1:0]        FC_LAST = FC_W'(FRAMES_PER_DECEL - 1);
    localparam logic signed [SPEED_W:0] ONE    = (SPEED_W+1)'(1);
    localparam logic signed [SPEED_W:0] ZERO   = '0;
    localparam logic signed [SPEED_W:0] VMAX_S = (SPEED_W+1)'(VMAX);
    localparam logic signed [10:0]      LO     = 11'(RADIUS);
    localparam logic signed [10:0]      HI_X   = 11'(H_ACTIVE - 1 - RADIUS);
    localparam logic signed [10:0]      HI_Y   = 11'(V_ACTIVE - 1 - RADIUS);
    localparam logic [21:0]             R_SQ   = 22'(RADIUS * RADIUS);

    state_t                    state;
    logic                      eof;
    logic [FC_W-1:0]           frame_cnt;
    logic                      decel_tick;
    logic [AXIS_W-1:0]         step_x, step_y;
    logic                      hit_x, hit_y;
    logic [9:0]                nx, ny;
    logic signed [SPEED_W-1:0] nsx, nsy;
    logic signed [10:0]        dx, dy;
    logic [10:0]               adx, ady;
    logic [21:0]               dist2;
    logic                      lit;

    // Returns {bounce, next_pos, next_speed}; a wall hit overrides accel and friction.
    function automatic logic [AXIS_W-1:0] axis_step(
        input logic [9:0]                pos,
        input logic signed [SPEED_W-1:0] speed,
        input logic                      inc,
        input logic                      dec,
        input logic                      friction,
        input logic signed [10:0]        hi
    );
        logic signed [SPEED_W:0]   accel, sum, s1;
        logic signed [10:0]        p;
        logic [9:0]                npos;
        logic signed [SPEED_W-1:0] nspeed;
        logic                      hit;
        accel = ZERO;
        if (inc && !dec)
            accel = ONE;
        else if (dec && !inc)
            accel = -ONE;
        sum = (SPEED_W+1)'(speed) + accel;
        s1 = sum;
        if (sum > VMAX_S)
            s1 = VMAX_S;
        else if (sum < -VMAX_S)
            s1 = -VMAX_S;
        if (accel == ZERO && friction) begin
            if (s1 > ZERO)
                s1 = s1 - ONE;
            else if (s1 < ZERO)
                s1 = s1 + ONE;
        end
        p = $signed({1'b0, pos}) + 11'(speed);
        if (p < LO) begin
            npos   = LO[9:0];
            nspeed = -speed;
            hit    = 1'b1;
        end else if (p > hi) begin
            npos   = hi[9:0];
            nspeed = -speed;
            hit    = 1'b1;
        end else begin
            npos   = p[9:0];
            nspeed = s1[SPEED_W-1:0];
            hit    = 1'b0;
        end
        return {hit, npos, nspeed};
    endfunction

    assign decel_tick = eof && (frame_cnt == FC_LAST);

    always_comb begin
        step_x = axis_step(ball_x, speed_x, button_r, button_l, decel_tick, HI_X);
        step_y = axis_step(ball_y, speed_y, button_d, button_u, decel_tick, HI_Y);
    end

    assign {hit_x, nx, nsx} = step_x;
    assign {hit_y, ny, nsy} = step_y;
    assign moving = (state == MOVING);

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            eof       <= 1'b0;
            frame_cnt <= '0;
            ball_x    <= 10'(START_X);
            ball_y    <= 10'(START_Y);
            speed_x   <= '0;
            speed_y   <= '0;
            state     <= IDLE;
            bounce    <= 1'b0;
        end else begin
            eof    <= (h_coord == 10'(H_ACTIVE - 1)) && (v_coord == 10'(V_ACTIVE - 1));
            bounce <= 1'b0;
            if (eof) begin
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
                if (button_c) begin
                    ball_x  <= 10'(START_X);
                    ball_y  <= 10'(START_Y);
                    speed_x <= '0;
                    speed_y <= '0;
                    state   <= IDLE;
                end else begin
                    ball_x  <= nx;
                    ball_y  <= ny;
                    speed_x <= nsx;
                    speed_y <= nsy;
                    bounce  <= hit_x | hit_y;
                    state   <= (nsx != '0 || nsy != '0) ? MOVING : IDLE;
                end
            end
        end
    end

    // |dx| never exceeds 1023, so the negation cannot overflow 11 bits.
    always_comb begin
        adx   = dx[10] ? 11'(-dx) : 11'(dx);
        ady   = dy[10] ? 11'(-dy) : 11'(dy);
        dist2 = 22'(adx) * 22'(adx) + 22'(ady) * 22'(ady);
        lit   = (dist2 <= R_SQ);
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            dx    <= '0;
            dy    <= '0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            dx    <= $signed({1'b0, h_coord}) - $signed({1'b0, ball_x});
            dy    <= $signed({1'b0, v_coord}) - $signed({1'b0, ball_y});
            red   <= lit ? COLOR[11:8] : 4'h0;
            green <= lit ? COLOR[7:4]  : 4'h0;
            blue  <= lit ? COLOR[3:0]  : 4'h0;
        end
    end

endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: directed and randomized frames checked against an
// integer model of the motion rules, plus circle-render checks with latency.
module tb_ball_physics;

    localparam int HA = 800, VA = 600, R = 10, VM = 15, SW = 6, FPD = 5;
    localparam int SX = 400, SY = 300;

    logic               pixel_clk = 1'b0;
    logic               rst_n;
    logic               button_u, button_d, button_l, button_r, button_c;
    logic [9:0]         h_coord, v_coord;
    logic [3:0]         red, green, blue;
    logic [9:0]         ball_x, ball_y;
    logic signed [SW-1:0] speed_x, speed_y;
    logic               moving, bounce;

    int checks = 0;
    int failures = 0;

    // reference model state
    int mx, my, msx, msy, mfc;
    bit mb;

    ball_physics #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .RADIUS(R), .VMAX(VM), .SPEED_W(SW),
        .FRAMES_PER_DECEL(FPD), .START_X(SX), .START_Y(SY), .COLOR(12'hFFF)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n),
        .button_u(button_u), .button_d(button_d), .button_l(button_l),
        .button_r(button_r), .button_c(button_c),
        .h_coord(h_coord), .v_coord(v_coord),
        .red(red), .green(green), .blue(blue),
        .ball_x(ball_x), .ball_y(ball_y),
        .speed_x(speed_x), .speed_y(speed_y),
        .moving(moving), .bounce(bounce)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = SX; my = SY; msx = 0; msy = 0; mfc = 0; mb = 0;
    endtask

    task automatic axis_model(input int pos, input int spd, input logic plus,
                              input logic minus, input int lim, input bit decel,
                              output int npos, output int nspd, output bit hit);
        int a, s, p;
        a = (plus && !minus) ? 1 : ((minus && !plus) ? -1 : 0);
        s = spd + a;
        if (s > VM) s = VM;
        if (s < -VM) s = -VM;
        if (a == 0 && decel && s != 0) s = (s > 0) ? s - 1 : s + 1;
        p = pos + spd;
        hit = 1'b1;
        nspd = -spd;
        if (p < R) npos = R;
        else if (p > lim - R) npos = lim - R;
        else begin
            npos = p; nspd = s; hit = 1'b0;
        end
    endtask

    task automatic model_frame(input logic u, d, l, r, c);
        bit decel, hx, hy;
        int nx, ny, nsx, nsy;
        decel = (mfc == FPD - 1);
        mfc = (mfc + 1) % FPD;
        if (c) begin
            mx = SX; my = SY; msx = 0; msy = 0; mb = 0;
        end else begin
            axis_model(mx, msx, r, l, HA - 1, decel, nx, nsx, hx);
            axis_model(my, msy, d, u, VA - 1, decel, ny, nsy, hy);
            mx = nx; my = ny; msx = nsx; msy = nsy; mb = hx | hy;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ball_x"}, ball_x, mx);
        chk({tag, "_ball_y"}, ball_y, my);
        chk({tag, "_speed_x"}, speed_x, msx);
        chk({tag, "_speed_y"}, speed_y, msy);
        chk({tag, "_moving"}, moving, (msx != 0 || msy != 0) ? 1 : 0);
        chk({tag, "_bounce"}, bounce, mb ? 1 : 0);
    endtask

    // One short frame: last active pixel, then the eof cycle, buttons held throughout.
    task automatic do_frame(input string tag, input logic u, d, l, r, c);
        button_u = u; button_d = d; button_l = l; button_r = r; button_c = c;
        h_coord = 10'(HA - 1); v_coord = 10'(VA - 1);
        @(negedge pixel_clk);
        h_coord = 10'd0; v_coord = 10'd0;
        @(negedge pixel_clk);
        model_frame(u, d, l, r, c);
        check_state(tag);
        button_u = 0; button_d = 0; button_l = 0; button_r = 0; button_c = 0;
        @(negedge pixel_clk);
        chk({tag, "_bounce_end"}, bounce, 0);
        mb = 0;
    endtask

    // Present (h,v) for one cycle, then a contrasting pixel; rgb two cycles later
    // must belong to (h,v).
    task automatic pix_check(input string tag, input int h, input int v);
        bit lit1;
        int dxm, dym;
        dxm = h - mx; dym = v - my;
        lit1 = (dxm * dxm + dym * dym) <= R * R;
        h_coord = 10'(h); v_coord = 10'(v);
        @(negedge pixel_clk);
        h_coord = lit1 ? 10'd0 : 10'(mx);
        v_coord = lit1 ? 10'd0 : 10'(my);
        @(negedge pixel_clk);
        chk(tag, {red, green, blue}, lit1 ? 12'hFFF : 12'h000);
    endtask

    initial begin
        int h, v, n;
        logic u, d, l, r, c;
        rst_n = 1'b0;
        button_u = 0; button_d = 0; button_l = 0; button_r = 0; button_c = 0;
        h_coord = 10'd0; v_coord = 10'd0;
        model_reset();
        repeat (3) @(negedge pixel_clk);
        check_state("reset");
        chk("reset_rgb", {red, green, blue}, 0);
        rst_n = 1'b1;

        repeat (3) do_frame("idle", 0, 0, 0, 0, 0);
        pix_check("pix_center", 400, 300);
        pix_check("pix_410_300", 410, 300);
        pix_check("pix_411_300", 411, 300);
        pix_check("pix_407_307", 407, 307);
        pix_check("pix_408_307", 408, 307);
        pix_check("pix_400_289", 400, 289);

        repeat (3) do_frame("accel_r", 0, 0, 0, 1, 0);
        repeat (20) do_frame("sat_r", 0, 0, 0, 1, 0);
        chk("sat_value", speed_x, 15);
        repeat (3) do_frame("l_and_r", 0, 0, 1, 1, 0);
        repeat (30) do_frame("to_wall_r", 0, 0, 0, 1, 0);
        repeat (40) do_frame("coast", 0, 0, 0, 0, 0);

        do_frame("home", 0, 0, 0, 0, 1);
        repeat (3) do_frame("fr_accel", 0, 0, 0, 1, 0);
        repeat (20) do_frame("friction", 0, 0, 0, 0, 0);
        chk("friction_stopped", moving, 0);
        repeat (40) do_frame("to_wall_u", 1, 0, 1, 0, 0);
        pix_check("pix_corner", mx, my - R);

        // Drive right until the model predicts a wall hit, then press centre on that frame.
        do_frame("home2", 0, 0, 0, 0, 1);
        n = 0;
        while (mx + msx <= HA - 1 - R && n < 100) begin
            do_frame("approach", 0, 0, 0, 1, 0);
            n++;
        end
        chk("approach_bound", (n < 100) ? 1 : 0, 1);
        do_frame("c_beats_bounce", 0, 0, 0, 1, 1);

        for (int i = 0; i < 300; i++) begin
            u = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 39) == 0);
            do_frame("rand", u, d, l, r, c);
            if (i % 4 == 0) begin
                h = mx + int'($urandom_range(0, 30)) - 15;
                v = my + int'($urandom_range(0, 30)) - 15;
                if (h < 0) h = 0;
                if (h > HA - 1) h = HA - 1;
                if (v < 0) v = 0;
                if (v > VA - 1) v = VA - 1;
                if (h == HA - 1 && v == VA - 1) h = HA - 2;
                pix_check("rand_pix", h, v);
            end
        end

        // Reset asserted during the eof cycle: no partial update may survive.
        repeat (4) do_frame("pre_rst", 0, 1, 0, 1, 0);
        button_r = 1; button_d = 1;
        h_coord = 10'(HA - 1); v_coord = 10'(VA - 1);
        @(negedge pixel_clk);
        h_coord = 10'd0; v_coord = 10'd0;
        rst_n = 1'b0;
        @(negedge pixel_clk);
        model_reset();
        check_state("mid_rst");
        chk("mid_rst_rgb", {red, green, blue}, 0);
        button_r = 0; button_d = 0;
        rst_n = 1'b1;
        repeat (2) do_frame("post_rst", 0, 0, 0, 1, 0);
        pix_check("post_rst_pix", mx + 3, my);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
